// File: rtl/disp_pkg.sv
// Shared constants, FSM encoding and leading-zero blanking helper for the
// display request scheduler.
package disp_pkg;

    localparam int VALUE_W = 14;
    localparam int DIGITS = 4;
    localparam int MAX_VALUE = 9999;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CONV  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // Replace leading zero digits with BLANK_CODE; the ones digit always stays.
    function automatic logic [DIGITS*4-1:0] blank_lz(input logic [DIGITS*4-1:0] bcd);
        logic [DIGITS*4-1:0] res;
        logic lead;
        res = bcd;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd[i*4 +: 4] == 4'd0)) begin
                res[i*4 +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_add3_shift.sv
// One combinational double-dabble step: add 3 to every nibble >= 5, then shift
// the BCD vector left by one with bit_in entering at the bottom.
module bcd_add3_shift
    import disp_pkg::*;
(
    input  logic [DIGITS*4-1:0] bcd_in,
    input  logic                bit_in,
    output logic [DIGITS*4-1:0] bcd_out,
    output logic                carry_out
);

    logic [DIGITS*4-1:0] adj_s;

    // Per-nibble add-3 correction ahead of the shift.
    always_comb begin
        adj_s = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*4 +: 4] >= 4'd5) begin
                adj_s[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
            end else begin
                adj_s[i*4 +: 4] = bcd_in[i*4 +: 4];
            end
        end
    end

    assign bcd_out   = {adj_s[DIGITS*4-2:0], bit_in};
    assign carry_out = adj_s[DIGITS*4-1];

endmodule

// File: rtl/disp_request_scheduler.sv
// Round-robin display sharing between two requesters with sequential binary to
// BCD conversion. Optional leading-zero blanking: define DISP_LZ_BLANK_EN.
module disp_request_scheduler
    import disp_pkg::*;
#(
    parameter int VALUE_W   = disp_pkg::VALUE_W,
    parameter int MAX_VALUE = disp_pkg::MAX_VALUE
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [VALUE_W-1:0] req0_value,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [VALUE_W-1:0] req1_value,
    output logic               req1_ready,
    output logic [3:0]         in0,
    output logic [3:0]         in1,
    output logic [3:0]         in2,
    output logic [3:0]         in3,
    output logic               owner,
    output logic               ovf,
    output logic               busy
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int STEP_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [VALUE_W-1:0] MAX_V     = VALUE_W'(MAX_VALUE);
    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(VALUE_W - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic                last_r;
    logic                sel_r;
    logic                ovf_pend_r;
    logic [VALUE_W-1:0]  bin_r;
    logic [BCD_W-1:0]    bcd_r;
    logic [STEP_W-1:0]   step_r;
    logic                ready0_r;
    logic                ready1_r;
    logic                busy_r;
    logic [BCD_W-1:0]    digits_r;
    logic                owner_r;
    logic                ovf_r;

    logic                any_valid_s;
    logic                grant_sel_s;
    logic [VALUE_W-1:0]  grant_value_s;
    logic                sat_s;
    logic                last_step_s;
    logic [BCD_W-1:0]    bcd_step_s;
    logic                carry_s;
    logic [BCD_W-1:0]    disp_s;

    assign any_valid_s   = req0_valid | req1_valid;
    // On a tie the pointer favours the requester not served last.
    assign grant_sel_s   = (req0_valid && req1_valid) ? ~last_r : req1_valid;
    assign grant_value_s = grant_sel_s ? req1_value : req0_value;
    assign sat_s         = (grant_value_s > MAX_V);
    assign last_step_s   = (step_r == LAST_STEP);

    bcd_add3_shift u_step (
        .bcd_in    (bcd_r),
        .bit_in    (bin_r[VALUE_W-1]),
        .bcd_out   (bcd_step_s),
        .carry_out (carry_s)
    );

`ifdef DISP_LZ_BLANK_EN
    assign disp_s = blank_lz(bcd_r);
`else
    assign disp_s = bcd_r;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: state_nxt_s = CONV;
            CONV: begin
                if (last_step_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            LOAD:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake and busy flags, registered from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready0_r <= 1'b0;
            ready1_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            ready0_r <= (state_r == IDLE) && any_valid_s && !grant_sel_s;
            ready1_r <= (state_r == IDLE) && any_valid_s && grant_sel_s;
            busy_r   <= (state_nxt_s != IDLE);
        end
    end

    // Capture, conversion datapath and display registers. The first shift
    // step runs in GRANT so the result lands 15 edges after the handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_r     <= 1'b1;
            sel_r      <= 1'b0;
            ovf_pend_r <= 1'b0;
            bin_r      <= '0;
            bcd_r      <= '0;
            step_r     <= '0;
            digits_r   <= '0;
            owner_r    <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        bin_r      <= sat_s ? MAX_V : grant_value_s;
                        bcd_r      <= '0;
                        step_r     <= '0;
                        sel_r      <= grant_sel_s;
                        ovf_pend_r <= sat_s;
                        last_r     <= grant_sel_s;
                    end else begin
                        step_r <= '0;
                    end
                end
                GRANT, CONV: begin
                    bin_r      <= bin_r << 1;
                    bcd_r      <= bcd_step_s;
                    step_r     <= step_r + STEP_W'(1);
                    ovf_pend_r <= ovf_pend_r | carry_s;
                end
                LOAD: begin
                    digits_r <= disp_s;
                    owner_r  <= sel_r;
                    ovf_r    <= ovf_pend_r;
                end
                default: begin
                    step_r <= '0;
                end
            endcase
        end
    end

    assign req0_ready = ready0_r;
    assign req1_ready = ready1_r;
    assign busy       = busy_r;
    assign in0        = digits_r[3:0];
    assign in1        = digits_r[7:4];
    assign in2        = digits_r[11:8];
    assign in3        = digits_r[15:12];
    assign owner      = owner_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_disp_request_scheduler.sv
// Directed self-checking bench for disp_request_scheduler; expected digits
// follow DISP_LZ_BLANK_EN when it is defined.
module tb_disp_request_scheduler;

    logic        clock;
    logic        reset;
    logic        req0_valid;
    logic [13:0] req0_value;
    logic        req0_ready;
    logic        req1_valid;
    logic [13:0] req1_value;
    logic        req1_ready;
    logic [3:0]  in0, in1, in2, in3;
    logic        owner, ovf, busy;
    logic [15:0] disp;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] shown;
    logic        bad;

`ifdef DISP_LZ_BLANK_EN
    localparam logic [15:0] E5  = 16'hFFF5;
    localparam logic [15:0] E42 = 16'hFF42;
    localparam logic [15:0] E77 = 16'hFF77;
    localparam logic [15:0] E0  = 16'hFFF0;
`else
    localparam logic [15:0] E5  = 16'h0005;
    localparam logic [15:0] E42 = 16'h0042;
    localparam logic [15:0] E77 = 16'h0077;
    localparam logic [15:0] E0  = 16'h0000;
`endif

    disp_request_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_value (req0_value),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_value (req1_value),
        .req1_ready (req1_ready),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .owner      (owner),
        .ovf        (ovf),
        .busy       (busy)
    );

    assign disp = {in3, in2, in1, in0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Grant edge: the chosen ready is high for the GRANT cycle only.
    task automatic expect_grant(input int who);
        @(posedge clock);
        @(negedge clock);
        chk("ready0", {31'd0, req0_ready}, (who == 0) ? 32'd1 : 32'd0);
        chk("ready1", {31'd0, req1_ready}, (who == 1) ? 32'd1 : 32'd0);
        chk("busy_grant", {31'd0, busy}, 32'd1);
    endtask

    // Display must hold the previous value until edge T+15, then update at once.
    task automatic expect_done(input logic [15:0] exp_disp, input logic exp_owner,
                               input logic exp_ovf);
        repeat (14) @(posedge clock);
        @(negedge clock);
        chk("busy_conv", {31'd0, busy}, 32'd1);
        chk("no_partial", {16'd0, disp}, {16'd0, shown});
        @(posedge clock);
        @(negedge clock);
        chk("digits", {16'd0, disp}, {16'd0, exp_disp});
        chk("owner", {31'd0, owner}, {31'd0, exp_owner});
        chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        chk("busy_done", {31'd0, busy}, 32'd0);
        shown = exp_disp;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req0_value = 14'd0;
        req1_valid = 1'b0;
        req1_value = 14'd0;
        shown      = 16'h0000;
        bad        = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_digits", {16'd0, disp}, 32'd0);
        chk("rst_flags", {27'd0, owner, ovf, busy, req0_ready, req1_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // req0 = 1234
        req0_value = 14'd1234;
        req0_valid = 1'b1;
        expect_grant(0);
        req0_valid = 1'b0;
        expect_done(16'h1234, 1'b0, 1'b0);
        chk("ready_after", {30'd0, req0_ready, req1_ready}, 32'd0);

        // req1 = 12000 saturates
        req1_value = 14'd12000;
        req1_valid = 1'b1;
        expect_grant(1);
        req1_valid = 1'b0;
        expect_done(16'h9999, 1'b1, 1'b1);

        // req1 = 5 clears ovf
        req1_value = 14'd5;
        req1_valid = 1'b1;
        expect_grant(1);
        req1_valid = 1'b0;
        expect_done(E5, 1'b1, 1'b0);

        // Both valid, pointer last=1 so req0 first, then alternation
        req0_value = 14'd42;
        req1_value = 14'd77;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        expect_grant(0);
        expect_done(E42, 1'b0, 1'b0);
        expect_grant(1);
        expect_done(E77, 1'b1, 1'b0);
        expect_grant(0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        expect_done(E42, 1'b0, 1'b0);

        // Boundary: exactly 9999 is not saturated, 10000 is
        req0_value = 14'd9999;
        req0_valid = 1'b1;
        expect_grant(0);
        req0_valid = 1'b0;
        expect_done(16'h9999, 1'b0, 1'b0);
        req0_value = 14'd10000;
        req0_valid = 1'b1;
        expect_grant(0);
        req0_valid = 1'b0;
        expect_done(16'h9999, 1'b0, 1'b1);

        // Reset 5 cycles into a conversion of 8888
        req0_value = 14'd8888;
        req0_valid = 1'b1;
        expect_grant(0);
        req0_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("abort_digits", {16'd0, disp}, 32'd0);
        chk("abort_flags", {27'd0, owner, ovf, busy, req0_ready, req1_ready}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        shown = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (disp !== 16'h0000 || busy !== 1'b0) bad = 1'b1;
        end
        chk("never_8888", {31'd0, bad}, 32'd0);

        // Value change during conversion: 1111 shown, 2222 on next grant
        req0_value = 14'd1111;
        req0_valid = 1'b1;
        expect_grant(0);
        req0_value = 14'd2222;
        expect_done(16'h1111, 1'b0, 1'b0);
        expect_grant(0);
        req0_valid = 1'b0;
        expect_done(16'h2222, 1'b0, 1'b0);

        // Value 0
        req1_value = 14'd0;
        req1_valid = 1'b1;
        expect_grant(1);
        req1_valid = 1'b0;
        expect_done(E0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
